sub_byte_serial: RTL and testbench
==================================

// Module: sub_byte_serial
// PURPOSE
// - Forward AES SubBytes engine for the encryption datapath; the encrypt-side counterpart of the decrypt path's inv_sub_byte.
// - Accepts a 128-bit state over a valid/ready handshake and substitutes LANES bytes per cycle through forward S-box instances.
// - Holds the result until the downstream stage takes it.
// - Sits between AddRoundKey and ShiftRows in the iterative round loop.
// - Trades latency for area: LANES=16 matches a full combinational SubBytes in one cycle.
// PARAMETERS
// - LANES  default 4  bytes substituted per cycle; legal values 1, 2, 4, 8, 16
// - Derived: STEPS = 16/LANES, cycles per block.
// PORTS
// - Clocking: one clock; reset is asynchronous and active-high.
// - clk        in   1    rising-edge clock
// - rst        in   1    async active-high reset
// - in_valid   in   1    in_data is valid
// - in_ready   out  1    engine can accept a block (IDLE only)
// - in_data    in   128  state, [0:127] ordering, byte i = in_data[8i:8i+7]
// - out_valid  out  1    out_data holds a completed block
// - out_ready  in   1    downstream accepts out_data
// - out_data   out  128  substituted state, same byte ordering
// - busy       out  1    high in BUSY or DONE
// BEHAVIOUR
// - Reset values: in_ready=1, out_valid=0, busy=0, out_data=0, step counter=0, state=IDLE.
// - FSM states: IDLE, BUSY, DONE.
// - IDLE:
//   - in_ready=1.
//   - On in_valid&&in_ready, latch in_data into the working register, clear the counter, go to BUSY.
// - BUSY:
//   - Each cycle, bytes cnt*LANES .. cnt*LANES+LANES-1 are replaced by S(byte).
//   - Each byte's S-box input is the high nibble and low nibble of the byte.
//   - Untouched bytes hold their value; cnt increments.
//   - After the step with cnt==STEPS-1, go to DONE. cnt wraps to 0.
// - DONE:
//   - out_valid=1; out_data is the working register.
//   - out_data is stable while out_valid && !out_ready.
//   - On out_ready, go to IDLE; out_valid drops the next cycle.
// - Latency:
//   - Input accepted at edge k gives out_valid high after edge k+STEPS.
//   - LANES=4: 4 cycles. LANES=16: 1 cycle.
// - in_ready is 0 in BUSY and DONE.
//   - in_valid is ignored there; the upstream stage must hold its data.
//   - No input is accepted in the same cycle an output is taken.
// - out_data register is 0 until the first completion.
//   - Afterwards it shows the working register, including partial values in BUSY; consumers must qualify it with out_valid.
// - S-box is the FIPS-197 forward table, purely combinational.
//   - All timing comes from the state and counter registers.
// - Reset asserted mid-operation:
//   - Immediately returns to the reset values and discards the block.
//   - No out_valid is produced for the aborted block.
// - out_ready while out_valid=0 has no effect.
// TESTING
// - Reset, then in_data=0 with LANES=4 -> out_valid after 4 cycles; out_data=63636363_63636363_63636363_63636363.
// - in_data=00010203_04050607_08090a0b_0c0d0e0f -> out_data=637c777b_f26b6fc5_3001672b_fed7ab76.
// - in_data all ff -> all 16; byte 53 at byte 0 -> ed at out_data[0:7], other bytes per table.
// - Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0.
//   - Then pulse out_ready -> IDLE, in_ready=1 the next cycle.
// - Assert rst at cycle 2 of BUSY -> out_valid=0 and in_ready=1 immediately, out_data=0.
//   - A new block after reset completes correctly.
// - Sweep LANES=1,2,8,16 with back-to-back blocks and out_ready tied 1:
//   - Latency is 16/LANES; spacing is 16/LANES+2 cycles per block.
//   - Results match a reference S-box model over 1000 random states.

Source files
------------

// File: rtl/sub_byte_serial.sv
// Forward AES SubBytes engine: a 128-bit state is substituted LANES bytes per cycle
// through combinational S-boxes, then held behind a valid/ready handshake.
module sub_byte_serial #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy
);
    localparam int STEPS = 16 / LANES;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    // FIPS-197 forward S-box, entry n occupies bits [8n:8n+7]
    localparam logic [0:2047] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [0:127]       work_q, work_d;
    logic               seen_q, seen_d;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TAB[8*int'(b) +: 8];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
        end
    end

    // Working register is pure data; out_data is masked by seen_q until a block completes.
    always_ff @(posedge clk) begin
        work_q <= work_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        seen_d  = seen_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int l = 0; l < LANES; l++) begin
                    work_d[8*(int'(cnt_q)*LANES + l) +: 8] =
                        sbox(work_q[8*(int'(cnt_q)*LANES + l) +: 8]);
                end
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    seen_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = seen_q ? work_q : '0;

endmodule

// File: tb/tb_sub_byte_serial.sv
// Directed and randomized checks of sub_byte_serial at LANES=4, plus a sweep of
// LANES=1,2,8,16 against an S-box derived from GF(2^8) inversion and the affine map.
module tb_sub_byte_serial;
    logic         clk = 1'b0;
    logic         rst;
    logic         iv, ir, ov, ordy, bz;
    logic [0:127] id, od;

    logic         sw_iv [4];
    logic         sw_ir [4];
    logic         sw_ov [4];
    logic         sw_bz [4];
    logic [0:127] sw_id [4];
    logic [0:127] sw_od [4];

    int           n_chk  = 0;
    int           n_pass = 0;
    int           cyc    = 0;
    logic [7:0]   ref_sb [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sub_byte_serial #(.LANES(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_data(id),
        .out_valid(ov), .out_ready(ordy), .out_data(od), .busy(bz));
    sub_byte_serial #(.LANES(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(sw_iv[0]), .in_ready(sw_ir[0]), .in_data(sw_id[0]),
        .out_valid(sw_ov[0]), .out_ready(1'b1), .out_data(sw_od[0]), .busy(sw_bz[0]));
    sub_byte_serial #(.LANES(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(sw_iv[1]), .in_ready(sw_ir[1]), .in_data(sw_id[1]),
        .out_valid(sw_ov[1]), .out_ready(1'b1), .out_data(sw_od[1]), .busy(sw_bz[1]));
    sub_byte_serial #(.LANES(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(sw_iv[2]), .in_ready(sw_ir[2]), .in_data(sw_id[2]),
        .out_valid(sw_ov[2]), .out_ready(1'b1), .out_data(sw_od[2]), .busy(sw_bz[2]));
    sub_byte_serial #(.LANES(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(sw_iv[3]), .in_ready(sw_ir[3]), .in_data(sw_id[3]),
        .out_valid(sw_ov[3]), .out_ready(1'b1), .out_data(sw_od[3]), .busy(sw_bz[3]));

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [0:127] ref_sub(input logic [0:127] s);
        logic [0:127] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_sb[s[8*i +: 8]];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // Drive one block into the LANES=4 instance and wait for completion (out_ready held low).
    task automatic run_block(input string tag, input logic [0:127] din,
                             input logic [0:127] exp, input logic first);
        int lat;
        iv = 1'b1;
        id = din;
        tick();
        iv = 1'b0;
        chk({tag, "_in_ready_busy"}, {127'd0, ir}, 128'd0);
        chk({tag, "_busy"}, {127'd0, bz}, 128'd1);
        if (first) chk({tag, "_outdata_zero"}, od, 128'd0);
        lat = 0;
        while (!ov && lat < 50) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'd4);
        chk({tag, "_data"}, od, exp);
    endtask

    task automatic release_out(input string tag);
        ordy = 1'b1;
        tick();
        ordy = 1'b0;
        chk({tag, "_ov_drop"}, {127'd0, ov}, 128'd0);
        chk({tag, "_in_ready"}, {127'd0, ir}, 128'd1);
    endtask

    initial begin
        logic [0:127] held;
        logic [0:127] din;
        int steps, lat, acc_prev, acc_now;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, s;
            inv = 8'h01;
            if (x == 0) inv = 8'h00;
            else for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            ref_sb[x] = s;
        end

        rst = 1'b1; iv = 1'b0; ordy = 1'b0; id = '0;
        for (int k = 0; k < 4; k++) begin
            sw_iv[k] = 1'b0;
            sw_id[k] = '0;
        end
        tick();
        tick();
        chk("rst_in_ready", {127'd0, ir}, 128'd1);
        chk("rst_out_valid", {127'd0, ov}, 128'd0);
        chk("rst_busy", {127'd0, bz}, 128'd0);
        chk("rst_out_data", od, 128'd0);
        rst = 1'b0;
        tick();

        run_block("zero", 128'h0, 128'h63636363_63636363_63636363_63636363, 1'b1);
        release_out("zero");
        run_block("seq", 128'h00010203_04050607_08090a0b_0c0d0e0f,
                  128'h637c777b_f26b6fc5_3001672b_fed7ab76, 1'b0);
        release_out("seq");
        run_block("ones", {128{1'b1}}, {16{8'h16}}, 1'b0);
        release_out("ones");
        run_block("b53", 128'h53000000_00000000_00000000_00000000,
                  128'hed636363_63636363_63636363_63636363, 1'b0);

        held = od;
        iv = 1'b1;
        id = 128'hdeadbeef_01234567_89abcdef_55aa55aa;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_ov", {127'd0, ov}, 128'd1);
            chk("hold_data", od, held);
            chk("hold_in_ready", {127'd0, ir}, 128'd0);
        end
        ordy = 1'b1;
        tick();
        ordy = 1'b0;
        iv = 1'b0;
        chk("take_ov_drop", {127'd0, ov}, 128'd0);
        chk("take_in_ready", {127'd0, ir}, 128'd1);
        chk("take_no_accept", {127'd0, bz}, 128'd0);

        ordy = 1'b1;
        tick();
        tick();
        ordy = 1'b0;
        chk("idle_ordy_no_ov", {127'd0, ov}, 128'd0);
        chk("idle_ordy_ready", {127'd0, ir}, 128'd1);

        iv = 1'b1;
        id = 128'h00112233_44556677_8899aabb_ccddeeff;
        tick();
        iv = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("abort_ov", {127'd0, ov}, 128'd0);
        chk("abort_in_ready", {127'd0, ir}, 128'd1);
        chk("abort_out_data", od, 128'd0);
        chk("abort_busy", {127'd0, bz}, 128'd0);
        tick();
        rst = 1'b0;
        lat = 0;
        while (!ov && lat < 8) begin
            tick();
            lat++;
        end
        chk("abort_no_late_ov", {127'd0, ov}, 128'd0);
        run_block("after_rst", 128'h00010203_04050607_08090a0b_0c0d0e0f,
                  128'h637c777b_f26b6fc5_3001672b_fed7ab76, 1'b1);
        release_out("after_rst");

        for (int k = 0; k < 4; k++) begin
            steps = (k == 0) ? 16 : (k == 1) ? 8 : (k == 2) ? 2 : 1;
            acc_prev = 0;
            for (int n = 0; n < 1000; n++) begin
                chk("sweep_in_ready", {127'd0, sw_ir[k]}, 128'd1);
                din = {$urandom, $urandom, $urandom, $urandom};
                sw_iv[k] = 1'b1;
                sw_id[k] = din;
                tick();
                sw_iv[k] = 1'b0;
                acc_now = cyc;
                if (n > 0) chk("sweep_spacing", 128'(acc_now - acc_prev), 128'(steps + 2));
                acc_prev = acc_now;
                lat = 0;
                while (!sw_ov[k] && lat < 50) begin
                    tick();
                    lat++;
                end
                chk("sweep_latency", 128'(lat), 128'(steps));
                chk("sweep_data", sw_od[k], ref_sub(din));
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
